// File: rtl/sfp_accumulator_pkg.sv
// Shared types and constants for the sfp post-processor.
// FSM state encoding and signed psum range helpers.
package sfp_accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  function automatic int psum_max(input int bw);
    return (1 << (bw - 1)) - 1;
  endfunction

  function automatic int psum_min(input int bw);
    return -(1 << (bw - 1));
  endfunction

endpackage

// File: rtl/sfp_lane.sv
// One accumulator lane: saturating add, clear, ReLU output.
// Ports: i_clr/i_add/i_last control, i_psum in, o_out result, o_sat clamp.
module sfp_lane
  import sfp_accumulator_pkg::*;
#(
  parameter int psum_bw = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_clr,
  input  logic               i_add,
  input  logic               i_last,
  input  logic               i_relu,
  input  logic [psum_bw-1:0] i_psum,
  output logic [psum_bw-1:0] o_out,
  output logic               o_sat
);

  localparam int MAX_I = psum_max(psum_bw);
  localparam int MIN_I = psum_min(psum_bw);
  localparam logic [psum_bw-1:0] MAXV = MAX_I[psum_bw-1:0];
  localparam logic [psum_bw-1:0] MINV = MIN_I[psum_bw-1:0];

  logic [psum_bw-1:0] r_acc;
  logic [psum_bw-1:0] r_out;
  logic [psum_bw:0]   w_sum;
  logic [psum_bw-1:0] w_sat_sum;
  logic               w_neg;

  assign w_sum = {r_acc[psum_bw-1], r_acc}
               + {i_psum[psum_bw-1], i_psum};

  // Top two bits disagree only when the sum left the psum range.
  assign o_sat = w_sum[psum_bw] ^ w_sum[psum_bw-1];

  always_comb begin
    w_sat_sum = w_sum[psum_bw-1:0];
    if (o_sat) begin
      w_sat_sum = w_sum[psum_bw] ? MINV : MAXV;
    end
  end

  assign w_neg = w_sat_sum[psum_bw-1];
  assign o_out = r_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
      r_out <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_add) begin
      r_acc <= w_sat_sum;
      if (i_last) begin
        r_out <= (i_relu && w_neg) ? '0 : w_sat_sum;
      end
    end
  end

endmodule

// File: rtl/sfp_accumulator.sv
// Accumulates num_acc psum vectors per job, saturating, optional ReLU.
// Ports: start/num_acc/relu_en, psum valid/ready in, sfp valid/ready out.
module sfp_accumulator
  import sfp_accumulator_pkg::*;
#(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [CNT_W-1:0]       num_acc,
  input  logic                   relu_en,
  input  logic [col*psum_bw-1:0] psum_in,
  input  logic                   psum_valid,
  output logic                   psum_ready,
  output logic [col*psum_bw-1:0] sfp_out,
  output logic                   sfp_valid,
  input  logic                   sfp_ready,
  output logic                   busy,
  output logic                   ovf
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_num;
  logic             r_relu;
  logic             r_ovf;
  logic             w_start_ok;
  logic             w_clr;
  logic             w_beat;
  logic             w_last;
  logic [col-1:0]   w_sat;

  assign w_start_ok = start && (num_acc != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_clr  = 1'b0;
    w_beat = 1'b0;
    w_last = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_start_ok) begin
          w_clr  = 1'b1;
          w_next = ACC;
        end
      end
      ACC: begin
        if (psum_valid) begin
          w_beat = 1'b1;
          if (r_cnt == r_num - 1'b1) begin
            w_last = 1'b1;
            w_next = OUT;
          end
        end
      end
      OUT: begin
        if (sfp_ready) begin
          if (w_start_ok) begin
            w_clr  = 1'b1;
            w_next = ACC;
          end else begin
            w_next = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_num  <= '0;
      r_relu <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_clr) begin
      r_cnt  <= '0;
      r_num  <= num_acc;
      r_relu <= relu_en;
      r_ovf  <= 1'b0;
    end else if (w_beat) begin
      r_cnt <= r_cnt + 1'b1;
      if (|w_sat) r_ovf <= 1'b1;
    end
  end

  genvar g;
  generate
    for (g = 0; g < col; g++) begin : g_lane
      sfp_lane #(
        .psum_bw(psum_bw)
      ) u_lane (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_clr),
        .i_add (w_beat),
        .i_last(w_last),
        .i_relu(r_relu),
        .i_psum(psum_in[psum_bw*g +: psum_bw]),
        .o_out (sfp_out[psum_bw*g +: psum_bw]),
        .o_sat (w_sat[g])
      );
    end
  endgenerate

  assign psum_ready = (r_state == ACC);
  assign sfp_valid  = (r_state == OUT);
  assign busy       = (r_state != IDLE);
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_sfp_accumulator.sv
// Self-checking bench for sfp_accumulator.
// Directed plan steps plus randomized jobs against an integer model.
module tb_sfp_accumulator;

  localparam int COL = 8;
  localparam int BW  = 16;
  localparam int CW  = 8;
  localparam int VW  = COL * BW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] num_acc = '0;
  logic          relu_en = 1'b0;
  logic [VW-1:0] psum_in = '0;
  logic          psum_valid = 1'b0;
  logic          psum_ready;
  logic [VW-1:0] sfp_out;
  logic          sfp_valid;
  logic          sfp_ready = 1'b0;
  logic          busy;
  logic          ovf;

  sfp_accumulator #(
    .col(COL), .psum_bw(BW), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .num_acc(num_acc), .relu_en(relu_en),
    .psum_in(psum_in), .psum_valid(psum_valid),
    .psum_ready(psum_ready), .sfp_out(sfp_out),
    .sfp_valid(sfp_valid), .sfp_ready(sfp_ready),
    .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int beats [16][COL];
  int exp_lane [COL];
  bit exp_ovf;

  task automatic chk(input string tag,
                     input logic [VW-1:0] obs,
                     input logic [VW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VW-1:0] pack_beat(input int b);
    logic [VW-1:0] v;
    int x;
    v = '0;
    for (int i = 0; i < COL; i++) begin
      x = beats[b][i];
      v[i*BW +: BW] = x[BW-1:0];
    end
    return v;
  endfunction

  function automatic logic [VW-1:0] pack_exp();
    logic [VW-1:0] v;
    int x;
    v = '0;
    for (int i = 0; i < COL; i++) begin
      x = exp_lane[i];
      v[i*BW +: BW] = x[BW-1:0];
    end
    return v;
  endfunction

  // Job result from plain integer arithmetic with clamping.
  task automatic model(input int n, input bit relu);
    int acc;
    exp_ovf = 1'b0;
    for (int i = 0; i < COL; i++) begin
      acc = 0;
      for (int b = 0; b < n; b++) begin
        acc = acc + beats[b][i];
        if (acc > 32767) begin
          acc = 32767;
          exp_ovf = 1'b1;
        end else if (acc < -32768) begin
          acc = -32768;
          exp_ovf = 1'b1;
        end
      end
      exp_lane[i] = (relu && acc < 0) ? 0 : acc;
    end
  endtask

  task automatic clear_beats();
    for (int b = 0; b < 16; b++)
      for (int i = 0; i < COL; i++)
        beats[b][i] = 0;
  endtask

  task automatic rand_beats(input int n, input bit big);
    for (int b = 0; b < n; b++)
      for (int i = 0; i < COL; i++)
        beats[b][i] = big
          ? int'($urandom_range(0, 65535)) - 32768
          : int'($urandom_range(0, 400)) - 200;
  endtask

  task automatic start_job(input int n, input bit relu);
    start = 1'b1;
    num_acc = CW'(n);
    relu_en = relu;
    tick();
    start = 1'b0;
    sfp_ready = 1'b0;
    chk("start_busy", VW'(busy), VW'(1));
    chk("start_pready", VW'(psum_ready), VW'(1));
    chk("start_valid", VW'(sfp_valid), VW'(0));
    chk("start_ovf_clr", VW'(ovf), VW'(0));
  endtask

  task automatic feed(input int n, input bit gaps);
    for (int b = 0; b < n; b++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          psum_valid = 1'b0;
          psum_in = {4{$urandom()}};
          tick();
        end
      end
      chk("beat_valid_low", VW'(sfp_valid), VW'(0));
      psum_valid = 1'b1;
      psum_in = pack_beat(b);
      tick();
    end
    psum_valid = 1'b0;
    chk("result_valid", VW'(sfp_valid), VW'(1));
    chk("result_pready", VW'(psum_ready), VW'(0));
  endtask

  task automatic check_result(input string tag);
    chk(tag, sfp_out, pack_exp());
    chk("ovf", VW'(ovf), VW'(exp_ovf));
  endtask

  task automatic release_out();
    sfp_ready = 1'b1;
    tick();
    sfp_ready = 1'b0;
    chk("rel_valid", VW'(sfp_valid), VW'(0));
    chk("rel_busy", VW'(busy), VW'(0));
    chk("rel_hold_out", sfp_out, pack_exp());
  endtask

  initial begin
    #1;
    chk("rst_out", sfp_out, '0);
    chk("rst_flags",
        VW'({psum_ready, sfp_valid, busy, ovf}), '0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("idle_busy", VW'(busy), VW'(0));

    // Plan 1: basic accumulation.
    clear_beats();
    beats[0][0] = 100; beats[1][0] = -30; beats[2][0] = 5;
    beats[0][7] = 1;   beats[1][7] = 2;   beats[2][7] = 3;
    model(3, 1'b0);
    start_job(3, 1'b0);
    feed(3, 1'b0);
    check_result("p1_out");
    release_out();

    // Plan 2: ReLU on a negative sum, then without ReLU.
    clear_beats();
    beats[0][0] = -20; beats[1][0] = -30;
    model(2, 1'b1);
    start_job(2, 1'b1);
    feed(2, 1'b0);
    check_result("p2_relu");
    release_out();
    model(2, 1'b0);
    start_job(2, 1'b0);
    feed(2, 1'b0);
    check_result("p2_norelu");
    release_out();

    // Plan 3: saturation both ways, next start clears ovf.
    clear_beats();
    beats[0][0] = 30000;  beats[1][0] = 10000;
    beats[0][1] = -30000; beats[1][1] = -10000;
    model(2, 1'b0);
    start_job(2, 1'b0);
    feed(2, 1'b0);
    check_result("p3_sat");
    release_out();
    chk("p3_ovf_sticky", VW'(ovf), VW'(1));
    clear_beats();
    rand_beats(2, 1'b0);
    model(2, 1'b0);
    start_job(2, 1'b0);
    feed(2, 1'b1);
    check_result("p3_after");

    // Plan 4: back-pressure, then handshake with start.
    for (int c = 0; c < 5; c++) begin
      psum_valid = c[0];
      psum_in = {4{$urandom()}};
      tick();
      chk("bp_valid", VW'(sfp_valid), VW'(1));
      chk("bp_pready", VW'(psum_ready), VW'(0));
      chk("bp_out", sfp_out, pack_exp());
    end
    psum_valid = 1'b0;
    clear_beats();
    beats[0][0] = 7;
    model(1, 1'b0);
    sfp_ready = 1'b1;
    start_job(1, 1'b0);
    feed(1, 1'b0);
    check_result("p4_b2b");
    release_out();

    // Plan 5: reset mid-job.
    clear_beats();
    beats[0][0] = 30000; beats[1][0] = 30000;
    start_job(4, 1'b0);
    for (int b = 0; b < 2; b++) begin
      psum_valid = 1'b1;
      psum_in = pack_beat(b);
      tick();
    end
    psum_valid = 1'b0;
    chk("p5_ovf_mid", VW'(ovf), VW'(1));
    reset = 1'b1;
    #1;
    chk("p5_rst_out", sfp_out, '0);
    chk("p5_rst_flags",
        VW'({psum_ready, sfp_valid, busy, ovf}), '0);
    tick();
    reset = 1'b0;
    tick();
    clear_beats();
    beats[0][0] = 9;
    model(1, 1'b0);
    start_job(1, 1'b0);
    feed(1, 1'b0);
    check_result("p5_fresh");
    release_out();

    // Plan 6: zero-length start ignored, bursty valid.
    start = 1'b1;
    num_acc = '0;
    psum_valid = 1'b1;
    psum_in = {4{$urandom()}};
    tick();
    start = 1'b0;
    psum_valid = 1'b0;
    chk("p6_busy", VW'(busy), VW'(0));
    chk("p6_pready", VW'(psum_ready), VW'(0));
    clear_beats();
    rand_beats(3, 1'b0);
    model(3, 1'b0);
    start_job(3, 1'b0);
    begin
      int b;
      bit pat [5];
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      b = 0;
      for (int c = 0; c < 5; c++) begin
        chk("p6_burst_valid", VW'(sfp_valid), VW'(0));
        psum_valid = pat[c];
        psum_in = pat[c] ? pack_beat(b) : {4{$urandom()}};
        if (pat[c]) b++;
        tick();
      end
    end
    psum_valid = 1'b0;
    chk("p6_done", VW'(sfp_valid), VW'(1));
    check_result("p6_out");
    release_out();

    // Randomized jobs.
    for (int j = 0; j < 24; j++) begin
      int n;
      bit r;
      n = $urandom_range(1, 6);
      r = $urandom_range(0, 1) != 0;
      clear_beats();
      rand_beats(n, $urandom_range(0, 1) != 0);
      model(n, r);
      start_job(n, r);
      feed(n, 1'b1);
      check_result("rand_out");
      release_out();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
